queue_dispatcher: RTL and testbench



---
 rtl/queue_dispatcher.sv | 86 ++++++++
 tb/tb_queue_dispatcher.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/queue_dispatcher.sv
// Write-side dispatcher: steers a ready/valid word stream into one of
// QUEUE_QUANTITY FIFOs by class field, stalling on almost-full.
module queue_dispatcher #(
  parameter int QUEUE_QUANTITY = 4,
  parameter int DATA_BITS      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enb,
  input  logic [DATA_BITS-1:0]      data_in,
  input  logic                      data_valid,
  output logic                      data_ready,
  input  logic [QUEUE_QUANTITY-1:0] buf_almost_full,
  output logic [QUEUE_QUANTITY-1:0] push,
  output logic [DATA_BITS-1:0]      data_out,
  output logic [7:0]                stall_count
);

  localparam int DEST_BITS = $clog2(QUEUE_QUANTITY);
  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_HELD  = 1'b1;
  localparam logic [QUEUE_QUANTITY-1:0] ONE = 1;

  logic [0:0]                state_q, state_d;
  logic [DATA_BITS-1:0]      hold_data_q, hold_data_d;
  logic [QUEUE_QUANTITY-1:0] push_q, push_d;
  logic [DATA_BITS-1:0]      data_out_q, data_out_d;
  logic [7:0]                stall_q, stall_d;

  logic [DEST_BITS-1:0] hold_dest;
  logic hold_valid;
  logic dest_full;
  logic drain;
  logic blocked;
  logic accept;

  assign hold_dest  = hold_data_q[DATA_BITS-1 -: DEST_BITS];
  assign hold_valid = (state_q == S_HELD);
  assign dest_full  = buf_almost_full[hold_dest];
  assign drain      = enb & hold_valid & ~dest_full;
  assign blocked    = enb & hold_valid & dest_full;

  // Gated by rst so the source never sees ready during reset.
  assign data_ready = ~rst & enb & (~hold_valid | drain);
  assign accept     = data_valid & data_ready;

  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    push_d      = '0;
    data_out_d  = data_out_q;
    stall_d     = stall_q;
    unique case (state_q)
      S_EMPTY: if (accept) state_d = S_HELD;
      S_HELD:  if (drain && !accept) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
    if (accept) hold_data_d = data_in;
    if (drain) begin
      push_d     = ONE << hold_dest;
      data_out_d = hold_data_q;
    end
    if (blocked && stall_q != 8'hFF) stall_d = stall_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      hold_data_q <= '0;
      push_q      <= '0;
      data_out_q  <= '0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      push_q      <= push_d;
      data_out_q  <= data_out_d;
      stall_q     <= stall_d;
    end
  end

  assign push        = push_q;
  assign data_out    = data_out_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_queue_dispatcher.sv
// Scoreboard bench for queue_dispatcher: stimulus queues expected pushes,
// a negedge monitor pops and compares each push it observes.
module tb_queue_dispatcher;

  logic       clk = 1'b0;
  logic       rst;
  logic       enb;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic [3:0] buf_almost_full;
  logic [3:0] push;
  logic [7:0] data_out;
  logic [7:0] stall_count;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0] p;
    logic [7:0] d;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  queue_dispatcher #(.QUEUE_QUANTITY(4), .DATA_BITS(8)) dut (
    .clk(clk),
    .rst(rst),
    .enb(enb),
    .data_in(data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .buf_almost_full(buf_almost_full),
    .push(push),
    .data_out(data_out),
    .stall_count(stall_count)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_push(input logic [3:0] p, input logic [7:0] d);
    exp_t e;
    e.p = p;
    e.d = d;
    sb.push_back(e);
  endtask

  // Monitor: every observed push must match the next queued word.
  always @(negedge clk) begin
    if (!rst && push != 4'b0) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL mon_unexpected: push=%b data=%h", push, data_out);
      end else begin
        e = sb.pop_front();
        if (push !== e.p || data_out !== e.d) begin
          errors++;
          $display("FAIL mon_word: got %b/%h want %b/%h",
                   push, data_out, e.p, e.d);
        end
      end
    end
  end

  initial begin
    logic [7:0] vec [4];
    vec[0] = 8'h05; vec[1] = 8'h45; vec[2] = 8'h85; vec[3] = 8'hC5;

    rst = 1'b1; enb = 1'b1; data_in = '0; data_valid = 1'b0;
    buf_almost_full = '0;
    step(); step();
    chk("rst_push", 32'(push), 32'h0);
    chk("rst_data_out", 32'(data_out), 32'h0);
    chk("rst_stall", 32'(stall_count), 32'h0);
    chk("rst_ready", 32'(data_ready), 32'h0);
    rst = 1'b0;
    #1;
    chk("rel_ready", 32'(data_ready), 32'h1);

    // Back-to-back stream, one per queue
    for (int i = 0; i < 4; i++) begin
      data_valid = 1'b1;
      data_in = vec[i];
      expect_push(4'b0001 << i, vec[i]);
      #1;
      chk("b2b_ready", 32'(data_ready), 32'h1);
      step();
    end
    data_valid = 1'b0;
    step();
    chk("b2b_last_push", 32'(push), 32'h8);
    chk("b2b_last_data", 32'(data_out), 32'hC5);
    step();

    // Blocked destination with a pending follower
    buf_almost_full = 4'b0100;
    data_valid = 1'b1;
    data_in = 8'h81;
    expect_push(4'b0100, 8'h81);
    step();
    data_in = 8'h02;
    expect_push(4'b0001, 8'h02);
    #1;
    chk("blk_ready", 32'(data_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("blk_push", 32'(push), 32'h0);
      chk("blk_ready_hold", 32'(data_ready), 32'h0);
    end
    chk("blk_stall3", 32'(stall_count), 32'd3);
    buf_almost_full = 4'b0000;
    #1;
    chk("unblk_ready", 32'(data_ready), 32'h1);
    step();
    data_valid = 1'b0;
    chk("unblk_push1", 32'(push), 32'h4);
    chk("unblk_data1", 32'(data_out), 32'h81);
    step();
    chk("unblk_push2", 32'(push), 32'h1);
    chk("unblk_data2", 32'(data_out), 32'h02);
    chk("unblk_stall", 32'(stall_count), 32'd3);
    step();

    // Enable freeze while holding 0x41
    data_valid = 1'b1;
    data_in = 8'h41;
    expect_push(4'b0010, 8'h41);
    step();
    data_valid = 1'b0;
    enb = 1'b0;
    #1;
    chk("frz_ready", 32'(data_ready), 32'h0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("frz_push", 32'(push), 32'h0);
      chk("frz_stall", 32'(stall_count), 32'd3);
    end
    enb = 1'b1;
    step();
    chk("frz_rel_push", 32'(push), 32'h2);
    chk("frz_rel_data", 32'(data_out), 32'h41);
    step();

    // Asynchronous reset discards a held, blocked word
    buf_almost_full = 4'b1000;
    data_valid = 1'b1;
    data_in = 8'hC3;
    step();
    data_valid = 1'b0;
    step();
    chk("ar_stall_pre", 32'(stall_count), 32'd4);
    #1;
    rst = 1'b1;
    #1;
    chk("ar_stall", 32'(stall_count), 32'h0);
    chk("ar_ready", 32'(data_ready), 32'h0);
    chk("ar_push", 32'(push), 32'h0);
    step();
    rst = 1'b0;
    buf_almost_full = 4'b0000;
    #1;
    chk("ar_rel_ready", 32'(data_ready), 32'h1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ar_no_push", 32'(push), 32'h0);
    end

    // Stall counter saturation
    buf_almost_full = 4'b0001;
    data_valid = 1'b1;
    data_in = 8'h00;
    expect_push(4'b0001, 8'h00);
    step();
    data_valid = 1'b0;
    for (int i = 0; i < 254; i++) step();
    chk("sat_254", 32'(stall_count), 32'd254);
    for (int i = 0; i < 46; i++) step();
    chk("sat_255", 32'(stall_count), 32'd255);
    step();
    chk("sat_hold", 32'(stall_count), 32'd255);
    buf_almost_full = 4'b0000;
    step();
    chk("sat_drain_push", 32'(push), 32'h1);
    step();
    step();
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
